// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the execute-stage branch resolve unit: opcodes,
// datapath width and flush FSM state encoding.
package branch_resolve_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  always_ff @(posedge clock) begin
    if (clear) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves bne/blt/j/jal/jr in X: registered redirect + jal link write,
// flush FSM squashing F/D and D/X, and saturating branch statistics.
//
// Handshake: an instruction is consumed on a rising edge where
// in_valid && in_ready; there is no back-pressure other than in_ready,
// and inputs offered while in_ready is low are dropped, not held.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           opcode,
  input  logic [XLEN-1:0]      pc,
  input  logic [16:0]          imm,
  input  logic [26:0]          target,
  input  logic [XLEN-1:0]      rd_value,
  input  logic                 isNotEqual,
  input  logic                 isLessThan,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 flush_fd,
  output logic                 flush_dx,
  output logic                 link_valid,
  output logic [XLEN-1:0]      link_value,
  output logic [CNT_W-1:0]     branch_count,
  output logic [CNT_W-1:0]     taken_count,
  output state_e               dbg_state
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              link_valid_q, link_valid_d;
  logic [XLEN-1:0]   link_value_q, link_value_d;

  logic              accept;
  logic              is_branch;
  logic              taken;
  logic [XLEN-1:0]   tgt;

  assign accept    = in_valid && (state_q == ST_IDLE);
  assign is_branch = (opcode == OP_BNE) || (opcode == OP_BLT);

  always_comb begin
    taken = 1'b0;
    tgt   = '0;
    case (opcode)
      OP_BNE: begin
        taken = isNotEqual;
        tgt   = pc + 32'd1 + {{15{imm[16]}}, imm};
      end
      OP_BLT: begin
        taken = isLessThan;
        tgt   = pc + 32'd1 + {{15{imm[16]}}, imm};
      end
      OP_J, OP_JAL: begin
        taken = 1'b1;
        tgt   = {5'b0, target};
      end
      OP_JR: begin
        taken = 1'b1;
        tgt   = rd_value;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    link_valid_d     = 1'b0;
    link_value_d     = link_value_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && taken) begin
          state_d          = ST_FLUSH;
          fcnt_d           = FC_W'(FLUSH_CYCLES - 1);
          redirect_valid_d = 1'b1;
          redirect_pc_d    = tgt;
          if (opcode == OP_JAL) begin
            link_valid_d = 1'b1;
            link_value_d = pc + 32'd1;
          end
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) state_d = ST_IDLE;
        else              fcnt_d  = fcnt_q - FC_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      fcnt_q           <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      link_valid_q     <= 1'b0;
      link_value_q     <= '0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      link_valid_q     <= link_valid_d;
      link_value_q     <= link_value_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clock (clock),
    .clear (reset),
    .en    (accept && is_branch),
    .count (branch_count)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clock (clock),
    .clear (reset),
    .en    (accept && is_branch && taken),
    .count (taken_count)
  );

  assign in_ready       = (state_q == ST_IDLE);
  assign flush_fd       = (state_q == ST_FLUSH);
  assign flush_dx       = (state_q == ST_FLUSH);
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign link_valid     = link_valid_q;
  assign link_value     = link_value_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: default build plus a CNT_W=4
// build sharing the same stimulus for the saturation scenario.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] pc = '0;
  logic [16:0] imm = '0;
  logic [26:0] target = '0;
  logic [31:0] rd_value = '0;
  logic        is_ne = 1'b0;
  logic        is_lt = 1'b0;

  logic        in_ready, redirect_valid, flush_fd, flush_dx, link_valid;
  logic [31:0] redirect_pc, link_value;
  logic [15:0] branch_count, taken_count;
  state_e      dbg_state;

  logic        in_ready4, redirect_valid4, flush_fd4, flush_dx4, link_valid4;
  logic [31:0] redirect_pc4, link_value4;
  logic [3:0]  branch_count4, taken_count4;
  state_e      dbg_state4;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clock = ~clock;

  branch_resolve_unit dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .pc(pc), .imm(imm), .target(target), .rd_value(rd_value),
    .isNotEqual(is_ne), .isLessThan(is_lt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_fd(flush_fd), .flush_dx(flush_dx),
    .link_valid(link_valid), .link_value(link_value),
    .branch_count(branch_count), .taken_count(taken_count),
    .dbg_state(dbg_state)
  );

  branch_resolve_unit #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .opcode(opcode), .pc(pc), .imm(imm), .target(target), .rd_value(rd_value),
    .isNotEqual(is_ne), .isLessThan(is_lt),
    .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
    .flush_fd(flush_fd4), .flush_dx(flush_dx4),
    .link_valid(link_valid4), .link_value(link_value4),
    .branch_count(branch_count4), .taken_count(taken_count4),
    .dbg_state(dbg_state4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // driver tasks: inputs change on the falling edge, outputs sampled there too
  task automatic step();
    @(negedge clock);
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] p, input logic [16:0] im,
                       input logic [26:0] tg, input logic [31:0] rv,
                       input logic ne, input logic lt);
    in_valid = 1'b1; opcode = op; pc = p; imm = im; target = tg;
    rd_value = rv; is_ne = ne; is_lt = lt;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; opcode = '0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // scoreboard: every redirect pulse must match the oldest expected target
  always @(negedge clock) begin
    if (redirect_valid) begin
      check("redir_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("redir_pc_sb", redirect_pc, exp_q.pop_front());
    end
  end

  initial begin
    step();
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_redir_v", 32'(redirect_valid), 32'd0);
    check("rst_redir_pc", redirect_pc, 32'd0);
    check("rst_flush", {30'd0, flush_fd, flush_dx}, 32'd0);
    check("rst_link", {31'd0, link_valid} | link_value, 32'd0);
    check("rst_counts", {branch_count, taken_count}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // 1: taken bne with negative offset
    drive(OP_BNE, 32'h100, 17'h1FFFC, '0, '0, 1'b1, 1'b0);
    exp_q.push_back(32'h0FD);
    step(); idle_in();
    check("s1_redir_v", 32'(redirect_valid), 32'd1);
    check("s1_redir_pc", redirect_pc, 32'h0FD);
    check("s1_flush_c1", {30'd0, flush_fd, flush_dx}, 32'd3);
    check("s1_ready_c1", 32'(in_ready), 32'd0);
    check("s1_state", 32'(dbg_state), 32'(ST_FLUSH));
    check("s1_bcount", 32'(branch_count), 32'd1);
    check("s1_tcount", 32'(taken_count), 32'd1);
    step();
    check("s1_redir_drop", 32'(redirect_valid), 32'd0);
    check("s1_flush_c2", {30'd0, flush_fd, flush_dx}, 32'd3);
    check("s1_ready_c2", 32'(in_ready), 32'd0);
    step();
    check("s1_flush_end", {30'd0, flush_fd, flush_dx}, 32'd0);
    check("s1_ready_back", 32'(in_ready), 32'd1);
    check("s1_pc_hold", redirect_pc, 32'h0FD);

    // 2: not-taken blt, then back-to-back accepts
    do_reset();
    drive(OP_BLT, 32'h40, 17'h10, '0, '0, 1'b0, 1'b0);
    step();
    check("s2_redir_v", 32'(redirect_valid), 32'd0);
    check("s2_flush", {30'd0, flush_fd, flush_dx}, 32'd0);
    check("s2_ready", 32'(in_ready), 32'd1);
    check("s2_bcount", 32'(branch_count), 32'd1);
    check("s2_tcount", 32'(taken_count), 32'd0);
    drive(5'b00000, 32'h41, '0, '0, '0, 1'b1, 1'b1);
    step();
    check("s2_nop_ready", 32'(in_ready), 32'd1);
    check("s2_nop_counts", {branch_count, taken_count}, {16'd1, 16'd0});
    drive(OP_BNE, 32'h42, 17'h5, '0, '0, 1'b0, 1'b1);
    step(); idle_in();
    check("s2_b2b_redir", 32'(redirect_valid), 32'd0);
    check("s2_b2b_counts", {branch_count, taken_count}, {16'd2, 16'd0});

    // 3: jal with link, jr during flush is dropped
    drive(OP_JAL, 32'h20, '0, 27'h0000123, '0, 1'b0, 1'b0);
    exp_q.push_back(32'h123);
    step();
    check("s3_redir_pc", redirect_pc, 32'h123);
    check("s3_link_v", 32'(link_valid), 32'd1);
    check("s3_link_val", link_value, 32'h21);
    drive(OP_JR, 32'h21, '0, '0, 32'h555, 1'b0, 1'b0);
    step();
    check("s3_link_drop", 32'(link_valid), 32'd0);
    check("s3_redir_drop", 32'(redirect_valid), 32'd0);
    step(); idle_in();
    check("s3_ready_back", 32'(in_ready), 32'd1);
    step();
    check("s3_no_2nd_redir", 32'(redirect_valid), 32'd0);
    check("s3_pc_hold", redirect_pc, 32'h123);
    check("s3_counts", {branch_count, taken_count}, {16'd2, 16'd0});

    // 4: jr to all-ones, then bne wrapping to zero
    drive(OP_JR, 32'h30, '0, '0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    exp_q.push_back(32'hFFFF_FFFF);
    step(); idle_in();
    check("s4_jr_pc", redirect_pc, 32'hFFFF_FFFF);
    step(); step();
    drive(OP_BNE, 32'hFFFF_FFFF, 17'h0, '0, '0, 1'b1, 1'b0);
    exp_q.push_back(32'h0);
    step(); idle_in();
    check("s4_wrap_v", 32'(redirect_valid), 32'd1);
    check("s4_wrap_pc", redirect_pc, 32'h0);
    step(); step();

    // 5: reset in first flush cycle, reset beats in_valid, then clean bne
    drive(OP_BNE, 32'h200, 17'h4, '0, '0, 1'b1, 1'b0);
    exp_q.push_back(32'h205);
    step(); idle_in();
    check("s5_flush_on", 32'(flush_fd), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("s5_flush_off", {30'd0, flush_fd, flush_dx}, 32'd0);
    check("s5_ready", 32'(in_ready), 32'd1);
    check("s5_counts", {branch_count, taken_count}, 32'd0);
    reset = 1'b1;
    drive(OP_BNE, 32'h300, 17'h4, '0, '0, 1'b1, 1'b0);
    step();
    reset = 1'b0; idle_in();
    check("s5_rst_wins_v", 32'(redirect_valid), 32'd0);
    check("s5_rst_wins_rdy", 32'(in_ready), 32'd1);
    check("s5_rst_wins_cnt", 32'(branch_count), 32'd0);
    drive(OP_BNE, 32'h100, 17'h1FFFC, '0, '0, 1'b1, 1'b0);
    exp_q.push_back(32'h0FD);
    step(); idle_in();
    check("s5_redir_pc", redirect_pc, 32'h0FD);
    check("s5_flush", {30'd0, flush_fd, flush_dx}, 32'd3);
    check("s5_counts_after", {branch_count, taken_count}, {16'd1, 16'd1});
    step();
    check("s5_flush_c2", 32'(flush_dx), 32'd1);
    step();
    check("s5_ready_back", 32'(in_ready), 32'd1);

    // 6: 20 taken blt; CNT_W=4 build saturates at 15
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(OP_BLT, 32'(i * 16), 17'h0, '0, '0, 1'b0, 1'b1);
      exp_q.push_back(32'(i * 16 + 1));
      step(); idle_in();
      step(); step();
    end
    check("s6_b4_sat", 32'(branch_count4), 32'd15);
    check("s6_t4_sat", 32'(taken_count4), 32'd15);
    check("s6_b16", 32'(branch_count), 32'd20);
    check("s6_t16", 32'(taken_count), 32'd20);
    check("s6_w4_pc", redirect_pc4, 32'(19 * 16 + 1));

    step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the 32-bit comparator flags (isNotEqual, isLessThan) in the pipelined core.
- Combines the flags with the decoded control-flow opcode and decides whether the branch or jump is taken.
- Produces a registered PC redirect and a link-register write for jal.
- Runs a small flush FSM that squashes the younger F/D and D/X instructions, and keeps saturating branch statistics counters.

Parameters:
FLUSH_CYCLES, 2, number of cycles flush_fd/flush_dx stay high after a taken redirect (>=1)
CNT_W, 16, width of the saturating statistics counters

Ports:
clock  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clock
in_valid  input  1  D/X latch holds a valid instruction this cycle
in_ready  output  1  unit accepts an instruction this cycle (high only in IDLE)
opcode  input  5  instruction opcode: 00010 bne, 00110 blt, 00001 j, 00011 jal, 00100 jr; others are non-control-flow
pc  input  32  PC of the instruction in D/X
imm  input  17  I-type immediate, two's complement
target  input  27  J-type target field T
rd_value  input  32  register value used by jr
isNotEqual  input  1  comparator flag: operands differ
isLessThan  input  1  comparator flag: branch less-than condition true
redirect_valid  output  1  one-cycle pulse, fetch loads redirect_pc
redirect_pc  output  32  new PC
flush_fd  output  1  squash F/D latch
flush_dx  output  1  squash D/X latch
link_valid  output  1  one-cycle pulse, write link_value into r31
link_value  output  32  pc+1 of the jal
branch_count  output  CNT_W  accepted bne/blt count, saturating
taken_count  output  CNT_W  taken bne/blt count, saturating

Behaviour:
- Reset (synchronous) drives the following to 0 on the next edge; in_ready reads 1 after reset:
  - state=IDLE, redirect_valid, redirect_pc, flush_fd, flush_dx, link_valid, link_value, branch_count, taken_count.
- Accept condition: in_valid && state==IDLE. Inputs presented while in FLUSH are discarded: no redirect, no link, no counting.
- Taken decision, evaluated in the accept cycle:
  - bne: taken = isNotEqual.
  - blt: taken = isLessThan.
  - j, jal, jr: always taken.
  - Any other opcode: not taken, no side effects.
- Target arithmetic (32-bit, wrap modulo 2^32, no overflow flag):
  - bne/blt: pc + 1 + sign-extend(imm).
  - j/jal: zero-extend(target).
  - jr: rd_value.
- Latency: accept at edge N → redirect_valid and redirect_pc valid in cycle N+1 for exactly one cycle. redirect_pc holds its value until the next redirect.
- jal: link_valid pulses in cycle N+1 with link_value = pc+1 (wraps at 0xFFFFFFFF → 0).
- FSM states:
  - IDLE: on a taken accept, go to FLUSH and load the counter with FLUSH_CYCLES-1.
  - FLUSH: flush_fd=flush_dx=1 and in_ready=0. Decrement the counter each cycle; when it is 0, return to IDLE on that edge.
  - Net effect: flush is high for exactly FLUSH_CYCLES cycles starting N+1, and in_ready returns high in cycle N+1+FLUSH_CYCLES.
- Not-taken branch: remain in IDLE, no flush, back-to-back accepts allowed every cycle.
- Counters:
  - branch_count increments on every accepted bne/blt.
  - taken_count increments on every accepted taken bne/blt.
  - Both saturate at 2^CNT_W-1; there is no wrap.
- Reset mid-FLUSH: on the next edge return to IDLE, drop flush, clear counters.
- reset and in_valid in the same cycle: reset wins and the instruction is not accepted.

Decomposition:
- Shared package holds the opcode constants (OP_BNE, OP_BLT, OP_J, OP_JAL, OP_JR), the FSM state encoding, and the XLEN=32 constant.
- One natural sub-module: sat_counter (CNT_W, synchronous clear, enable), instantiated twice.
- The target adder is computed inline.

Test Plan:
1. bne, isNotEqual=1, pc=0x100, imm=0x1FFFC (-4) → next cycle redirect_valid=1, redirect_pc=0x0FD; flush_fd/dx high 2 cycles; in_ready low 2 cycles; branch_count=1, taken_count=1.
2. blt, isLessThan=0, pc=0x40, followed by an accept on every subsequent cycle → no redirect, no flush, in_ready stays 1; branch_count=1, taken_count=0.
3. jal, pc=0x20, target=0x0000123 → redirect_pc=0x123, link_valid=1, link_value=0x21. An in_valid jr issued during the flush is ignored (no second redirect).
4. jr with rd_value=0xFFFFFFFF, then bne taken with pc=0xFFFFFFFF, imm=0 → redirect_pc=0xFFFFFFFF, then 0x00000000 (wrap).
5. Assert reset in the first flush cycle → next cycle flush_fd=flush_dx=0, in_ready=1, counters=0. A subsequent taken bne behaves as in scenario 1.
6. CNT_W=4 build, 20 taken blt accepts → branch_count=taken_count=15 (saturated).
